// File: rtl/rv_dp_pkg.sv
// Shared encodings for the multi-cycle RV32 datapath and its controller.
package rv_dp_pkg;

   typedef logic [31:0] word_t;

   localparam logic       PC_INC    = 1'b0;
   localparam logic       PC_ALU    = 1'b1;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   localparam logic [1:0] IMM_I     = 2'd0;
   localparam logic [1:0] IMM_L     = 2'd1;
   localparam logic [1:0] IMM_S     = 2'd2;
   localparam logic [1:0] IMM_B     = 2'd3;

   localparam logic [1:0] ALUA_REG  = 2'd0;
   localparam logic [1:0] ALUA_PCC  = 2'd1;
   localparam logic [1:0] ALUA_OUT  = 2'd2;

   localparam logic [1:0] ALUB_REG  = 2'd0;
   localparam logic [1:0] ALUB_IMM  = 2'd1;
   localparam logic [1:0] ALUB_C    = 2'd2;

   // ALU codes are {funct3, instr[30]}
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_SLL   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_XOR   = 4'b1000;
   localparam logic [3:0] ALU_SRL   = 4'b1010;
   localparam logic [3:0] ALU_SRA   = 4'b1011;
   localparam logic [3:0] ALU_OR    = 4'b1100;
   localparam logic [3:0] ALU_AND   = 4'b1110;

endpackage

// File: rtl/rv_dp_if.sv
// Control and memory bus between the datapath and its controller/memories.
import rv_dp_pkg::*;

interface rv_dp_if;
   logic       pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
   logic [1:0] wbsel, immsel, asel, bsel;
   logic [3:0] alusel;
   word_t      instr;
   logic       zero;
   word_t      imem_addr, imem_rdata;
   word_t      dmem_addr, dmem_wdata, dmem_rdata;

   modport master (
      output pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite,
      output wbsel, immsel, asel, bsel, alusel,
      output imem_rdata, dmem_rdata,
      input  instr, zero, imem_addr, dmem_addr, dmem_wdata
   );

   modport slave (
      input  pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite,
      input  wbsel, immsel, asel, bsel, alusel,
      input  imem_rdata, dmem_rdata,
      output instr, zero, imem_addr, dmem_addr, dmem_wdata
   );
endinterface

// File: rtl/rv_dp_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hardwired to 0.
module rv_regfile
   import rv_dp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] raddr1_i,
   input  logic [4:0] raddr2_i,
   input  logic       we_i,
   input  logic [4:0] waddr_i,
   input  word_t      wdata_i,
   output word_t      rdata1_o,
   output word_t      rdata2_o
);

   word_t regs_q [32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/rv_dp.sv
// Multi-cycle RV32I datapath: PC/PCC/IR/MDR/ALUOut/A/B registers, inline ALU and immediate generator.
module rv_dp
   import rv_dp_pkg::*;
#(
   parameter word_t RESET_PC   = 32'h0000_0000,
   parameter word_t ALUB_C_VAL = 32'hFFFF_FFFF
) (
   input  logic clk,
   input  logic rst,
   rv_dp_if.slave bus
);

   function automatic word_t imm_gen(input logic [1:0] sel, input word_t ir);
      case (sel)
         IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         default: return {{20{ir[31]}}, ir[31:20]};
      endcase
   endfunction

   function automatic word_t alu_f(input logic [3:0] op, input word_t a, input word_t b);
      logic signed [31:0] as_v;
      logic signed [31:0] bs_v;
      logic        [4:0]  sh;
      as_v = a;
      bs_v = b;
      sh   = b[4:0];
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << sh;
         ALU_SLT:  return {31'b0, (as_v < bs_v)};
         ALU_SLTU: return {31'b0, (a < b)};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return as_v >>> sh;
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return '0;
      endcase
   endfunction

   word_t pc_q, pc_d, pcc_q, pcc_d, ir_q, ir_d, mdr_q, mdr_d;
   word_t aluout_q, a_q, b_q;
   word_t rs1_data, rs2_data, imm, opa, opb, alu_res, wb_data;

   rv_regfile u_rf (
      .clk      (clk),
      .rst      (rst),
      .raddr1_i (ir_q[19:15]),
      .raddr2_i (ir_q[24:20]),
      .we_i     (bus.regwen),
      .waddr_i  (ir_q[11:7]),
      .wdata_i  (wb_data),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   always_comb begin
      pc_d = pc_q;
      if (bus.pcwrite) pc_d = (bus.pcsourse == PC_ALU) ? aluout_q : pc_q + 32'd4;
      pcc_d = bus.pccen    ? pc_q           : pcc_q;
      ir_d  = bus.irwrite  ? bus.imem_rdata : ir_q;
      mdr_d = bus.mdrwrite ? bus.dmem_rdata : mdr_q;
   end

   always_comb begin
      imm = imm_gen(bus.immsel, ir_q);
      case (bus.asel)
         ALUA_REG: opa = a_q;
         ALUA_PCC: opa = pcc_q;
         ALUA_OUT: opa = aluout_q;
         default:  opa = '0;
      endcase
      case (bus.bsel)
         ALUB_REG: opb = b_q;
         ALUB_IMM: opb = imm;
         ALUB_C:   opb = ALUB_C_VAL;
         default:  opb = '0;
      endcase
      alu_res = alu_f(bus.alusel, opa, opb);
      case (bus.wbsel)
         WB_ALUOUT: wb_data = aluout_q;
         WB_MDR:    wb_data = mdr_q;
         WB_PC:     wb_data = pc_q;
         default:   wb_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         pcc_q    <= '0;
         ir_q     <= '0;
         mdr_q    <= '0;
         aluout_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         pc_q     <= pc_d;
         pcc_q    <= pcc_d;
         ir_q     <= ir_d;
         mdr_q    <= mdr_d;
         aluout_q <= alu_res;
         a_q      <= rs1_data;
         b_q      <= rs2_data;
      end
   end

   assign bus.instr      = ir_q;
   assign bus.zero       = (alu_res == '0);
   assign bus.imem_addr  = pc_q;
   assign bus.dmem_addr  = aluout_q;
   assign bus.dmem_wdata = b_q;

endmodule

// File: tb/tb_rv_dp.sv
// Bench for rv_dp: directed scenarios plus random control traffic against a behavioural model.
module tb_rv_dp;
   import rv_dp_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rv_dp_if bus();
   rv_dp dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   logic [31:0] m_pc, m_pcc, m_ir, m_mdr, m_alu, m_a, m_b;
   logic [31:0] m_rf [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_imm(input logic [1:0] sel, input logic [31:0] ir);
      if (sel == IMM_S) return 32'($signed({ir[31:25], ir[11:7]}));
      if (sel == IMM_B) return 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      return 32'($signed(ir[31:20]));
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a << sh;
         4'b0100: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'b0110: return (a < b) ? 32'd1 : 32'd0;
         4'b1000: return a ^ b;
         4'b1010: return a >> sh;
         4'b1011: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'b1100: return a | b;
         4'b1110: return a & b;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_pcc = '0; m_ir = '0; m_mdr = '0; m_alu = '0; m_a = '0; m_b = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
   endtask

   task automatic idle();
      bus.pcsourse = 1'b0; bus.pcwrite = 1'b0; bus.pccen = 1'b0;
      bus.irwrite = 1'b0; bus.regwen = 1'b0; bus.mdrwrite = 1'b0;
      bus.wbsel = 2'd0; bus.immsel = 2'd0; bus.asel = 2'd0; bus.bsel = 2'd0;
      bus.alusel = 4'd0;
   endtask

   // One clock: check combinational zero, advance the model, check the registered outputs.
   task automatic cycle();
      logic [31:0] opa, opb, res, wb, n_pc;
      logic [4:0]  rd;
      #1;
      opa = (bus.asel == 2'd0) ? m_a : (bus.asel == 2'd1) ? m_pcc : (bus.asel == 2'd2) ? m_alu : 32'h0;
      opb = (bus.bsel == 2'd0) ? m_b : (bus.bsel == 2'd1) ? ref_imm(bus.immsel, m_ir) :
            (bus.bsel == 2'd2) ? 32'hFFFF_FFFF : 32'h0;
      res = ref_alu(bus.alusel, opa, opb);
      chk("zero", {31'b0, bus.zero}, {31'b0, (res == 32'h0)});
      wb = (bus.wbsel == 2'd0) ? m_alu : (bus.wbsel == 2'd1) ? m_mdr : (bus.wbsel == 2'd2) ? m_pc : 32'h0;
      n_pc = !bus.pcwrite ? m_pc : (bus.pcsourse ? m_alu : m_pc + 32'd4);
      rd = m_ir[11:7];
      @(posedge clk); #1;
      m_a   = m_rf[m_ir[19:15]];
      m_b   = m_rf[m_ir[24:20]];
      if (bus.regwen && rd != 5'd0) m_rf[rd] = wb;
      if (bus.pccen)    m_pcc = m_pc;
      if (bus.irwrite)  m_ir  = bus.imem_rdata;
      if (bus.mdrwrite) m_mdr = bus.dmem_rdata;
      m_alu = res;
      m_pc  = n_pc;
      chk("imem_addr",  bus.imem_addr,  m_pc);
      chk("instr",      bus.instr,      m_ir);
      chk("dmem_addr",  bus.dmem_addr,  m_alu);
      chk("dmem_wdata", bus.dmem_wdata, m_b);
      chk("pcc",        dut.pcc_q,      m_pcc);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("rst_imem_addr", bus.imem_addr, 32'h0);
      chk("rst_instr",     bus.instr,     32'h0);
      chk("rst_dmem_addr", bus.dmem_addr, 32'h0);
   endtask

   task automatic load_ir(input logic [31:0] w);
      idle(); bus.imem_rdata = w; bus.irwrite = 1'b1; cycle(); idle();
   endtask

   // Route a value into a register through MDR writeback.
   task automatic set_reg(input logic [4:0] r, input logic [31:0] val);
      idle();
      bus.dmem_rdata = val; bus.mdrwrite = 1'b1;
      bus.imem_rdata = {20'h0, r, 7'h33}; bus.irwrite = 1'b1;
      cycle();
      idle(); bus.regwen = 1'b1; bus.wbsel = WB_MDR;
      cycle();
      idle();
   endtask

   initial begin
      bus.imem_rdata = '0;
      bus.dmem_rdata = '0;
      idle();
      rst = 1'b1;
      #12;

      // Fetch
      do_reset();
      bus.imem_rdata = 32'h0050_0093;
      bus.pccen = 1'b1; bus.pcwrite = 1'b1; bus.irwrite = 1'b1; bus.pcsourse = PC_INC;
      cycle();
      chk("fetch_pc",    bus.imem_addr, 32'd4);
      chk("fetch_pcc",   dut.pcc_q,     32'd0);
      chk("fetch_instr", bus.instr,     32'h0050_0093);

      // ALU add and writeback
      set_reg(5'd1, 32'd7);
      set_reg(5'd2, 32'hFFFF_FFFD);
      load_ir(32'h0020_81B3);
      cycle();
      bus.asel = ALUA_REG; bus.bsel = ALUB_REG; bus.alusel = ALU_ADD;
      cycle();
      idle(); bus.regwen = 1'b1; bus.wbsel = WB_ALUOUT;
      cycle();
      idle();
      chk("add_x3", dut.u_rf.regs_q[3], 32'd4);

      // Branch target and compare
      do_reset();
      set_reg(5'd1, 32'd5);
      set_reg(5'd2, 32'd5);
      bus.pcwrite = 1'b1; bus.pcsourse = PC_INC;
      cycle(); cycle();
      idle(); bus.pccen = 1'b1;
      cycle();
      chk("br_pcc", dut.pcc_q, 32'd8);
      load_ir(32'h0020_8863);
      cycle();
      bus.asel = ALUA_PCC; bus.bsel = ALUB_IMM; bus.immsel = IMM_B; bus.alusel = ALU_ADD;
      cycle();
      chk("br_target", bus.dmem_addr, 32'd24);
      idle();
      bus.asel = ALUA_REG; bus.bsel = ALUB_REG; bus.alusel = ALU_SUB;
      bus.pcwrite = 1'b1; bus.pcsourse = PC_ALU;
      #1;
      chk("br_zero", {31'b0, bus.zero}, 32'd1);
      cycle();
      idle();
      chk("br_pc", bus.imem_addr, 32'd24);

      // Load path, including a write aimed at x0
      set_reg(5'd5, 32'hDEAD_BEEF);
      chk("load_x5", dut.u_rf.regs_q[5], 32'hDEAD_BEEF);
      set_reg(5'd0, 32'hDEAD_BEEF);
      chk("load_x0", dut.u_rf.regs_q[0], 32'h0);

      // PC wrap and arithmetic shift by an out-of-range amount
      load_ir(32'h0040_0013);
      bus.asel = 2'd3; bus.bsel = ALUB_IMM; bus.immsel = IMM_I; bus.alusel = ALU_SUB;
      cycle();
      idle(); bus.pcwrite = 1'b1; bus.pcsourse = PC_ALU;
      cycle();
      chk("wrap_pre", bus.imem_addr, 32'hFFFF_FFFC);
      idle(); bus.pcwrite = 1'b1; bus.pcsourse = PC_INC;
      cycle();
      idle();
      chk("wrap_pc", bus.imem_addr, 32'h0);
      set_reg(5'd1, 32'h8000_0000);
      set_reg(5'd2, 32'd33);
      load_ir(32'h0020_81B3);
      cycle();
      bus.alusel = ALU_SRA;
      cycle();
      idle();
      chk("sra", bus.dmem_addr, 32'hC000_0000);

      // Asynchronous reset in the middle of a writeback
      load_ir({20'h0, 5'd6, 7'h33});
      bus.asel = 2'd3; bus.bsel = ALUB_C; bus.alusel = ALU_ADD;
      cycle();
      idle(); bus.regwen = 1'b1; bus.wbsel = WB_ALUOUT;
      #3;
      rst = 1'b1;
      #1;
      chk("arst_instr", bus.instr,     32'h0);
      chk("arst_imem",  bus.imem_addr, 32'h0);
      chk("arst_dmem",  bus.dmem_addr, 32'h0);
      chk("arst_x1",    dut.u_rf.regs_q[1], 32'h0);
      @(posedge clk); #1;
      chk("arst_x6",    dut.u_rf.regs_q[6], 32'h0);
      rst = 1'b0;
      idle();
      model_reset();

      // Random control traffic
      for (int n = 0; n < 400; n++) begin
         bus.pcsourse   = 1'($urandom);
         bus.pcwrite    = 1'($urandom);
         bus.pccen      = 1'($urandom);
         bus.irwrite    = 1'($urandom);
         bus.regwen     = 1'($urandom);
         bus.mdrwrite   = 1'($urandom);
         bus.wbsel      = 2'($urandom);
         bus.immsel     = 2'($urandom);
         bus.asel       = 2'($urandom);
         bus.bsel       = 2'($urandom);
         bus.alusel     = 4'($urandom);
         bus.imem_rdata = $urandom;
         bus.dmem_rdata = $urandom;
         cycle();
      end
      idle();
      for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), dut.u_rf.regs_q[i], m_rf[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rv_dp.md
RV_DP -- requirements
Module: rv_dp

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter ALUB_C_VAL, default 32'hFFFF_FFFF, constant driven on ALU operand B when bsel=ALUB_C.
REQ-003 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 SHALL have control inputs, 1 bit each: pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite.
REQ-006 SHALL have control inputs wbsel[1:0], immsel[1:0], asel[1:0], bsel[1:0] and alusel[3:0].
REQ-007 SHALL have output instr[31:0], the current IR contents.
REQ-008 SHALL have output zero, 1 bit, high when the combinational ALU result equals 0.
REQ-009 SHALL have output imem_addr[31:0] driven from PC, and input imem_rdata[31:0] as combinational instruction-memory read data.
REQ-010 SHALL have output dmem_addr[31:0] driven from ALUOut, output dmem_wdata[31:0] driven from register B, and input dmem_rdata[31:0] as combinational data-memory read data.

Function
REQ-011 SHALL hold architectural registers PC, PCC, IR, MDR, ALUOut, A and B, each 32 bits.
REQ-012 SHALL load PCC<=PC when pccen=1.
REQ-013 SHALL load PC<=PC+4 when pcwrite=1 and pcsourse=PC_INC, or PC<=ALUOut when pcwrite=1 and pcsourse=PC_ALU.
REQ-014 SHALL, when pccen and pcwrite are both 1, load PCC with the pre-update PC.
REQ-015 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-016 SHALL load IR<=imem_rdata when irwrite=1 and MDR<=dmem_rdata when mdrwrite=1.
REQ-017 SHALL load ALUOut, A and B unconditionally every cycle, from the ALU result, rf[rs1] and rf[rs2] respectively.
REQ-018 SHALL decode register indices from IR only: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7].
REQ-019 SHALL extend immediates by sign: IMM_I and IMM_L use I-format IR[31:20], IMM_S uses S-format, IMM_B uses B-format with bit0=0.
REQ-020 SHALL select ALU A as: ALUA_REG -> A, ALUA_PCC -> PCC, ALUA_OUT -> ALUOut; any other code -> 0.
REQ-021 SHALL select ALU B as: ALUB_REG -> B, ALUB_IMM -> selected immediate, ALUB_C -> ALUB_C_VAL; any other code -> 0.
REQ-022 SHALL decode alusel={funct3,instr30} as: ADD 0000, SUB 0001, SLL 0010, SLT 0100 (signed), SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110; every other code yields 0.
REQ-023 SHALL use only operand-B bits [4:0] as the shift amount; SLT and SLTU results are 32'h0 or 32'h1.
REQ-024 SHALL write rf[rd] on the clock edge when regwen=1, with data: WB_ALUOUT -> ALUOut, WB_MDR -> MDR, WB_PC -> PC; WB code 2'b11 writes 0.
REQ-025 SHALL ignore writes to x0, which always reads 0.
REQ-026 SHALL use the pre-edge IR for rd when regwen and irwrite are both 1 in the same cycle.
REQ-027 SHALL make register-file reads asynchronous; a read of the register written in the same cycle returns the old value.

Reset
REQ-028 SHALL, on rst, asynchronously clear PCC, IR, MDR, ALUOut, A, B and all 32 register-file entries to 0, and set PC=RESET_PC.
REQ-029 SHALL, while rst is high, hold instr=0, imem_addr=RESET_PC and dmem_addr=0; an in-flight register write in the asserting cycle is discarded.

Structure
REQ-030 SHALL take the following encodings from the shared params package and define no local copies: PC_INC=0/PC_ALU=1; WB_ALUOUT=0/WB_MDR=1/WB_PC=2; IMM_I=0/IMM_L=1/IMM_S=2/IMM_B=3; ALUA_REG=0/ALUA_PCC=1/ALUA_OUT=2; ALUB_REG=0/ALUB_IMM=1/ALUB_C=2; ALU_* codes.
REQ-031 SHALL implement the register file as sub-module rv_regfile (2 async read ports, 1 sync write port, async reset); the ALU and immediate generator stay inline.

Verification
REQ-032 SHALL test fetch: reset, imem_rdata=32'h00500093, pccen=pcwrite=irwrite=1 for one cycle -> PC=4, PCC=0, instr=32'h00500093.
REQ-033 SHALL test ALU and writeback: IR=add x3,x1,x2 with x1=7, x2=-3; asel=bsel=REG, alusel=0000 for one cycle; next cycle regwen=1, wbsel=WB_ALUOUT -> x3=4.
REQ-034 SHALL test branch: PCC=8, IMM_B=+16, ALUA_PCC+ALUB_IMM ADD for one cycle; then SUB with A=B=5 -> zero=1, and pcwrite=1 with PC_ALU -> PC=24.
REQ-035 SHALL test load path: dmem_rdata=32'hDEAD_BEEF, mdrwrite=1 for one cycle; next cycle regwen=1, WB_MDR, rd=5 -> x5=32'hDEAD_BEEF; the same sequence with rd=0 leaves x0=0.
REQ-036 SHALL test boundaries: PC=32'hFFFF_FFFC with a PC_INC write -> PC=0; SRA of 32'h8000_0000 by operand B=33 -> 32'hC000_0000.
REQ-037 SHALL test reset mid-operation: assert rst asynchronously between edges with regwen=1 -> all registers immediately reset and no write occurs.
